cpu_csr_exec: RTL and testbench

Executes Zicsr instructions (CSRRW/S/C and their immediate forms) against the CPU CSR file, immediately upstream of it. Accepts one CSR request from the execute stage and drives the CSR file's read port. Consumes the CSR file's registered read data one cycle later, computes the read-modify-write value, and drives the CSR file's write port. Returns the old CSR value for rd, flags illegal accesses, and produces the retired pulse that the CSR file's instret counter consumes.

---
 rtl/cpu_csr_exec_pkg.sv | 20 ++
 rtl/cpu_csr_alu.sv | 50 +++++
 rtl/cpu_csr_exec.sv | 146 ++++++++++++++
 tb/tb_cpu_csr_exec.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_csr_exec_pkg.sv
// Shared types for the Zicsr execution block: funct3 encodings, CSR address type and
// the read-only address predicate.
package cpu_csr_exec_pkg;

    typedef logic [11:0] csr_t;

    typedef enum logic [2:0] {
        CSRRW  = 3'b001,
        CSRRS  = 3'b010,
        CSRRC  = 3'b011,
        CSRRWI = 3'b101,
        CSRRSI = 3'b110,
        CSRRCI = 3'b111
    } csr_funct3_t;

    function automatic logic csr_is_read_only(input csr_t addr);
        return addr[11:10] == 2'b11;
    endfunction

endpackage

// File: rtl/cpu_csr_alu.sv
// Combinational read-modify-write for Zicsr: new value, write decision and illegal flag.
module cpu_csr_alu
    import cpu_csr_exec_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  csr_t            csr_i,
    input  logic [XLEN-1:0] old_i,
    input  logic [XLEN-1:0] src_i,
    input  logic            rs1_zero_i,
    output logic [XLEN-1:0] new_o,
    output logic            do_write_o,
    output logic            illegal_o
);

    always_comb begin
        new_o      = src_i;
        do_write_o = 1'b0;
        illegal_o  = 1'b0;
        case (funct3_i)
            CSRRW, CSRRWI: begin
                new_o      = src_i;
                do_write_o = 1'b1;
            end
            CSRRS: begin
                new_o      = old_i | src_i;
                do_write_o = !rs1_zero_i;
            end
            CSRRC: begin
                new_o      = old_i & ~src_i;
                do_write_o = !rs1_zero_i;
            end
            // Immediate src is the zero-extended zimm, so src != 0 is zimm != 0.
            CSRRSI: begin
                new_o      = old_i | src_i;
                do_write_o = |src_i;
            end
            CSRRCI: begin
                new_o      = old_i & ~src_i;
                do_write_o = |src_i;
            end
            default: illegal_o = 1'b1;
        endcase
        if (do_write_o && csr_is_read_only(csr_i)) begin
            illegal_o = 1'b1;
        end
    end

endmodule

// File: rtl/cpu_csr_exec.sv
// Zicsr executor sitting in front of the CSR file: IDLE -> RD -> WB -> RSP per request.
// Define CSR_EXEC_BACK2BACK_EN to accept the next request on the response handshake.
module cpu_csr_exec
    import cpu_csr_exec_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      req_funct3_i,
    input  csr_t            req_csr_i,
    input  logic [XLEN-1:0] req_rs1_data_i,
    input  logic [4:0]      req_zimm_i,
    input  logic            req_rs1_zero_i,
    input  logic            req_rd_zero_i,
    output csr_t            csr_read_addr_o,
    output logic            csr_read_enable_o,
    input  logic [XLEN-1:0] csr_read_data_i,
    output csr_t            csr_write_addr_o,
    output logic [XLEN-1:0] csr_write_data_o,
    output logic            csr_write_enable_o,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] resp_rd_data_o,
    output logic            resp_illegal_o,
    output logic            retired_o
);

    typedef enum logic [1:0] {StIdle, StRd, StWb, StRsp} state_e;

    state_e          state_q, state_d;
    logic [2:0]      funct3_q;
    csr_t            csr_q;
    logic [XLEN-1:0] src_q;
    logic [XLEN-1:0] rd_data_q;
    logic            rs1_zero_q;
    logic            rd_zero_q;
    logic            illegal_q;
    logic            init_done_q;

    logic            accept;
    logic            read_suppressed;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] new_val;
    logic            do_write;
    logic            alu_illegal;

    // CSRRW/CSRRWI with rd=x0 must not cause read side effects.
    assign read_suppressed = (funct3_q[1:0] == 2'b01) && rd_zero_q;
    assign old_val         = read_suppressed ? '0 : csr_read_data_i;
    assign accept          = req_valid_i && req_ready_o;

    cpu_csr_alu #(
        .XLEN(XLEN)
    ) u_alu (
        .funct3_i  (funct3_q),
        .csr_i     (csr_q),
        .old_i     (old_val),
        .src_i     (src_q),
        .rs1_zero_i(rs1_zero_q),
        .new_o     (new_val),
        .do_write_o(do_write),
        .illegal_o (alu_illegal)
    );

    always_comb begin
        state_d            = state_q;
        req_ready_o        = 1'b0;
        csr_read_addr_o    = '0;
        csr_read_enable_o  = 1'b0;
        csr_write_addr_o   = '0;
        csr_write_data_o   = '0;
        csr_write_enable_o = 1'b0;
        resp_valid_o       = 1'b0;
        resp_rd_data_o     = '0;
        resp_illegal_o     = 1'b0;
        retired_o          = 1'b0;
        case (state_q)
            StIdle: begin
                // Held low for the first cycle after reset so every output is 0 in reset.
                req_ready_o = init_done_q;
                if (req_valid_i && init_done_q) begin
                    state_d = StRd;
                end
            end
            StRd: begin
                csr_read_addr_o   = csr_q;
                csr_read_enable_o = !read_suppressed;
                state_d           = StWb;
            end
            StWb: begin
                csr_write_addr_o   = csr_q;
                csr_write_data_o   = new_val;
                csr_write_enable_o = do_write && !alu_illegal;
                state_d            = StRsp;
            end
            StRsp: begin
                resp_valid_o   = 1'b1;
                resp_rd_data_o = rd_data_q;
                resp_illegal_o = illegal_q;
                if (resp_ready_i) begin
                    retired_o = !illegal_q;
                    state_d   = StIdle;
`ifdef CSR_EXEC_BACK2BACK_EN
                    req_ready_o = 1'b1;
                    if (req_valid_i) begin
                        state_d = StRd;
                    end
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= StIdle;
            init_done_q <= 1'b0;
            funct3_q    <= '0;
            csr_q       <= '0;
            src_q       <= '0;
            rs1_zero_q  <= 1'b0;
            rd_zero_q   <= 1'b0;
            rd_data_q   <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_done_q <= 1'b1;
            if (accept) begin
                funct3_q   <= req_funct3_i;
                csr_q      <= req_csr_i;
                src_q      <= req_funct3_i[2] ? {{(XLEN - 5){1'b0}}, req_zimm_i} : req_rs1_data_i;
                rs1_zero_q <= req_rs1_zero_i;
                rd_zero_q  <= req_rd_zero_i;
            end
            if (state_q == StWb) begin
                rd_data_q <= old_val;
                illegal_q <= alu_illegal;
            end
        end
    end

endmodule

// File: tb/tb_cpu_csr_exec.sv
// Self-checking bench for cpu_csr_exec with a behavioural CSR file and reference model.
module tb_cpu_csr_exec;

    logic        clk = 1'b0;
    logic        reset_ni;
    logic        req_valid, req_ready;
    logic [2:0]  req_funct3;
    logic [11:0] req_csr;
    logic [31:0] req_rs1_data;
    logic [4:0]  req_zimm;
    logic        req_rs1_zero, req_rd_zero;
    logic [11:0] csr_read_addr, csr_write_addr;
    logic        csr_read_enable, csr_write_enable;
    logic [31:0] csr_read_data, csr_write_data;
    logic        resp_valid, resp_ready, resp_illegal, retired;
    logic [31:0] resp_rd_data;

    logic [31:0] csr_mem [4096] = '{default: 32'h0};
    logic [31:0] ref_mem [4096] = '{default: 32'h0};

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu_csr_exec #(
        .XLEN(32)
    ) dut (
        .clk_i             (clk),
        .reset_ni          (reset_ni),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_funct3_i      (req_funct3),
        .req_csr_i         (req_csr),
        .req_rs1_data_i    (req_rs1_data),
        .req_zimm_i        (req_zimm),
        .req_rs1_zero_i    (req_rs1_zero),
        .req_rd_zero_i     (req_rd_zero),
        .csr_read_addr_o   (csr_read_addr),
        .csr_read_enable_o (csr_read_enable),
        .csr_read_data_i   (csr_read_data),
        .csr_write_addr_o  (csr_write_addr),
        .csr_write_data_o  (csr_write_data),
        .csr_write_enable_o(csr_write_enable),
        .resp_valid_o      (resp_valid),
        .resp_ready_i      (resp_ready),
        .resp_rd_data_o    (resp_rd_data),
        .resp_illegal_o    (resp_illegal),
        .retired_o         (retired)
    );

    // CSR file: registered read port, write lands at the clock edge.
    always @(posedge clk) begin
        if (csr_read_enable) csr_read_data <= csr_mem[csr_read_addr];
        if (csr_write_enable) csr_mem[csr_write_addr] <= csr_write_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctl"}, {26'h0, req_ready, csr_read_enable, csr_write_enable, resp_valid,
                              retired, resp_illegal}, 32'h0);
        check({tag, "_addr"}, {8'h0, csr_read_addr, csr_write_addr}, 32'h0);
        check({tag, "_wdata"}, csr_write_data, 32'h0);
        check({tag, "_rdata"}, resp_rd_data, 32'h0);
    endtask

    task automatic scramble_req();
        req_funct3   = 3'($urandom);
        req_csr      = 12'($urandom);
        req_rs1_data = $urandom;
        req_zimm     = 5'($urandom);
        req_rs1_zero = 1'($urandom);
        req_rd_zero  = 1'($urandom);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accept_timeout"}, 32'(n < 20), 32'h1);
    endtask

    // One full request, starting and ending at a falling edge.
    task automatic do_req(input string tag, input logic [2:0] f3, input logic [11:0] csr,
                          input logic [31:0] rs1, input logic [4:0] zimm, input logic rs1_zero,
                          input logic rd_zero, input int stall);
        logic [31:0] cur, src, exp_old, exp_new, wdata, rd_seen;
        logic [11:0] raddr, waddr;
        logic        rw, supp, dw, ill, exp_wr, ill_seen, exp_rr;
        int          n, re_cnt, we_cnt;

        cur     = ref_mem[csr];
        rw      = (f3 == 3'b001) || (f3 == 3'b101);
        supp    = rw && rd_zero;
        exp_old = supp ? 32'h0 : cur;
        src     = f3[2] ? {27'h0, zimm} : rs1;
        case (f3[1:0])
            2'b01:   exp_new = src;
            2'b10:   exp_new = exp_old | src;
            2'b11:   exp_new = exp_old & ~src;
            default: exp_new = exp_old;
        endcase
        dw     = rw ? 1'b1 : (f3[2] ? (zimm != 5'h0) : !rs1_zero);
        ill    = (f3[1:0] == 2'b00) || (dw && csr[11:10] == 2'b11);
        exp_wr = dw && !ill;
        if (exp_wr) ref_mem[csr] = exp_new;

        req_funct3   = f3;
        req_csr      = csr;
        req_rs1_data = rs1;
        req_zimm     = zimm;
        req_rs1_zero = rs1_zero;
        req_rd_zero  = rd_zero;
        req_valid    = 1'b1;
        wait_ready(tag);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        scramble_req();

        n      = 1;
        re_cnt = 0;
        we_cnt = 0;
        raddr  = '0;
        waddr  = '0;
        wdata  = '0;
        while (!resp_valid && n < 10) begin
            if (csr_read_enable) begin
                re_cnt++;
                raddr = csr_read_addr;
            end
            if (csr_write_enable) begin
                we_cnt++;
                waddr = csr_write_addr;
                wdata = csr_write_data;
            end
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd3);
        check({tag, "_re_cnt"}, 32'(re_cnt), 32'(!supp));
        if (!supp) check({tag, "_raddr"}, {20'h0, raddr}, {20'h0, csr});
        rd_seen  = resp_rd_data;
        ill_seen = resp_illegal;

        for (int k = 0; k < stall; k++) begin
            if (csr_write_enable) we_cnt++;
            check({tag, "_stall_valid"}, {31'h0, resp_valid}, 32'h1);
            check({tag, "_stall_rd"}, resp_rd_data, rd_seen);
            check({tag, "_stall_ill"}, {31'h0, resp_illegal}, {31'h0, ill_seen});
            check({tag, "_stall_retired"}, {31'h0, retired}, 32'h0);
            check({tag, "_stall_ready"}, {31'h0, req_ready}, 32'h0);
            @(negedge clk);
        end

        resp_ready = 1'b1;
        #1;
        if (csr_write_enable) we_cnt++;
`ifdef CSR_EXEC_BACK2BACK_EN
        exp_rr = 1'b1;
`else
        exp_rr = 1'b0;
`endif
        check({tag, "_valid"}, {31'h0, resp_valid}, 32'h1);
        check({tag, "_rd_data"}, resp_rd_data, exp_old);
        check({tag, "_illegal"}, {31'h0, resp_illegal}, {31'h0, ill});
        check({tag, "_retired"}, {31'h0, retired}, {31'h0, !ill});
        check({tag, "_rsp_ready"}, {31'h0, req_ready}, {31'h0, exp_rr});
        check({tag, "_we_cnt"}, 32'(we_cnt), 32'(exp_wr));
        if (exp_wr) begin
            check({tag, "_waddr"}, {20'h0, waddr}, {20'h0, csr});
            check({tag, "_wdata"}, wdata, exp_new);
        end
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        check({tag, "_done_valid"}, {31'h0, resp_valid}, 32'h0);
        check({tag, "_mem"}, csr_mem[csr], ref_mem[csr]);
    endtask

    // Reset asserted in RD (phase 1) or WB (phase 2) of a write that must not land.
    task automatic reset_mid(input string tag, input int phase);
        req_funct3   = 3'b001;
        req_csr      = 12'h340;
        req_rs1_data = $urandom | 32'h1;
        req_zimm     = 5'h0;
        req_rs1_zero = 1'b0;
        req_rd_zero  = 1'b0;
        req_valid    = 1'b1;
        wait_ready(tag);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        if (phase == 2) @(negedge clk);
        reset_ni = 1'b0;
        #1;
        check_outputs_zero(tag);
        @(posedge clk);
        @(negedge clk);
        check_outputs_zero({tag, "_held"});
        check({tag, "_nowrite"}, csr_mem[12'h340], ref_mem[12'h340]);
        reset_ni = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [11:0] csr_pool [5];
        logic [2:0]  f3;
        logic [4:0]  zimm;
        logic [31:0] rs1;
        logic        rs1z, rdz;

        csr_pool   = '{12'h305, 12'h340, 12'h300, 12'hC00, 12'hF11};
        reset_ni   = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        scramble_req();
        repeat (2) @(negedge clk);
        check_outputs_zero("por");
        reset_ni = 1'b1;
        @(negedge clk);

        do_req("rw305", 3'b001, 12'h305, 32'h0000_1000, 5'h0, 1'b0, 1'b0, 0);
        do_req("rs305_z", 3'b010, 12'h305, 32'h0, 5'h0, 1'b1, 1'b0, 0);
        do_req("rsi305", 3'b110, 12'h305, $urandom, 5'h10, 1'b0, 1'b0, 0);
        do_req("rci305", 3'b111, 12'h305, $urandom, 5'h10, 1'b0, 1'b0, 0);
        do_req("rwi_rdz", 3'b101, 12'h305, $urandom, 5'h05, 1'b0, 1'b1, 0);
        do_req("rw_f14", 3'b001, 12'hF14, 32'h1234, 5'h0, 1'b0, 1'b0, 0);
        do_req("rs_f14_z", 3'b010, 12'hF14, 32'h0, 5'h0, 1'b1, 1'b0, 0);
        do_req("f3_000", 3'b000, 12'h300, 32'hFF, 5'h3, 1'b0, 1'b0, 0);
        do_req("f3_100", 3'b100, 12'h300, 32'hFF, 5'h3, 1'b0, 1'b0, 0);
        do_req("stall", 3'b011, 12'h305, 32'h1, 5'h0, 1'b0, 1'b0, 3);

        reset_mid("rst_rd", 1);
        do_req("after_rst_rd", 3'b010, 12'h340, 32'h0, 5'h0, 1'b1, 1'b0, 0);
        reset_mid("rst_wb", 2);
        do_req("after_rst_wb", 3'b001, 12'h340, 32'hCAFE_0001, 5'h0, 1'b0, 1'b0, 1);

`ifdef CSR_EXEC_BACK2BACK_EN
        begin
            int n;
            req_funct3   = 3'b010;
            req_csr      = 12'h305;
            req_rs1_data = 32'h0;
            req_zimm     = 5'h0;
            req_rs1_zero = 1'b1;
            req_rd_zero  = 1'b0;
            req_valid    = 1'b1;
            wait_ready("b2b");
            @(posedge clk);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!resp_valid && n < 10);
            check("b2b_first_valid", {31'h0, resp_valid}, 32'h1);
            resp_ready = 1'b1;
            #1;
            check("b2b_ready_on_rsp", {31'h0, req_ready}, 32'h1);
            check("b2b_first_rd", resp_rd_data, ref_mem[12'h305]);
            @(posedge clk);
            @(negedge clk);
            req_valid  = 1'b0;
            resp_ready = 1'b0;
            check("b2b_second_rd_en", {31'h0, csr_read_enable}, 32'h1);
            check("b2b_second_raddr", {20'h0, csr_read_addr}, 32'h305);
            n = 0;
            while (!resp_valid && n < 10) begin
                @(negedge clk);
                n++;
            end
            check("b2b_second_latency", 32'(n), 32'd2);
            resp_ready = 1'b1;
            #1;
            check("b2b_second_rd", resp_rd_data, ref_mem[12'h305]);
            check("b2b_second_retired", {31'h0, retired}, 32'h1);
            @(posedge clk);
            @(negedge clk);
            resp_ready = 1'b0;
        end
`endif

        for (int i = 0; i < 40; i++) begin
            f3   = 3'($urandom_range(0, 7));
            zimm = ($urandom_range(0, 3) == 0) ? 5'h0 : 5'($urandom);
            rdz  = ($urandom_range(0, 3) == 0);
            if (f3[2]) begin
                rs1z = (zimm == 5'h0);
                rs1  = $urandom;
            end else begin
                rs1z = ($urandom_range(0, 3) == 0);
                rs1  = rs1z ? 32'h0 : $urandom;
            end
            do_req($sformatf("rnd%0d", i), f3, csr_pool[$urandom_range(0, 4)], rs1, zimm, rs1z,
                   rdz, int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
